// File: rtl/rle_vga_pkg.sv
// Shared types and word layout for the VGA RLE pixel path.
// A run word is {run_len[RUN_W-1:0], colour[COLOUR_W-1:0]}; run_len of 0 marks end of frame.
package rle_vga_pkg;

  localparam int RUN_W       = 10;
  localparam int COLOUR_W    = 6;
  localparam int WORD_W      = RUN_W + COLOUR_W;
  localparam int RLE_EOF_RUN = 0;

  localparam int RUN_MSB    = WORD_W - 1;
  localparam int RUN_LSB    = COLOUR_W;
  localparam int COLOUR_MSB = COLOUR_W - 1;
  localparam int COLOUR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACTIVE     = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

endpackage

// File: rtl/rle_run_expander_if.sv
// Run-word stream from the flash word reader into the RLE expander.
// Handshake: a word transfers on every rising clk edge where word_valid and word_ready are both high;
// the master holds word_in stable while word_valid is high and ready is low, and ready may depend on valid.
interface rle_run_expander_if #(
  parameter int W = 16
);
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/rle_word_skid.sv
// One-entry prefetch slot: accepts a word when empty or when the held word is popped
// in the same cycle, so a continuous pop stream keeps the input ready every cycle.
module rle_word_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid
);

  logic         full;
  logic [W-1:0] head_q;
  logic         push;

  assign in_ready   = !full || pop;
  assign push       = in_valid && in_ready;
  assign head       = head_q;
  assign head_valid = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      head_q <= '0;
    end else begin
      if (push) begin
        head_q <= in_word;
        full   <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rle_run_expander.sv
// RLE run expander: turns run words into one registered colour per pix_en strobe.
// Build option RLE_HOLD_ON_UNDERRUN_EN: underrun pixels repeat the last colour instead of black.
module rle_run_expander
  import rle_vga_pkg::*;
#(
  parameter int RUN_W    = rle_vga_pkg::RUN_W,
  parameter int COLOUR_W = rle_vga_pkg::COLOUR_W
) (
  input  logic                clk,
  input  logic                rst,
  rle_run_expander_if.slave   bus,
  input  logic                frame_start,
  input  logic                pix_en,
  input  logic                clear_err,
  output logic [COLOUR_W-1:0] colour,
  output logic                underrun,
  output logic                desync,
  output state_t              state_dbg,
  output logic [RUN_W-1:0]    remaining_dbg
);

  localparam int BUS_W = RUN_W + COLOUR_W;

  state_t              state, state_nx;
  logic [RUN_W-1:0]    remaining, remaining_nx;
  logic [COLOUR_W-1:0] cur_colour, cur_colour_nx;
  logic [COLOUR_W-1:0] colour_nx, blank_colour;
  logic                drop, drop_nx;
  logic                pop, underrun_set, desync_set;

  logic [BUS_W-1:0]    head;
  logic                head_valid;
  logic [RUN_W-1:0]    head_run;
  logic [COLOUR_W-1:0] head_colour;
  logic                head_eof;
  logic                pix, rem_zero, exhausted;

  rle_word_skid #(.W(BUS_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_word    (bus.word_in),
    .in_valid   (bus.word_valid),
    .in_ready   (bus.word_ready),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid)
  );

  assign head_run    = head[BUS_W-1 -: RUN_W];
  assign head_colour = head[COLOUR_W-1:0];
  assign head_eof    = head_valid && (head_run == RUN_W'(RLE_EOF_RUN));

  // frame_start outranks a coincident pix_en, so that strobe is never a pixel.
  assign pix       = pix_en && !frame_start;
  assign rem_zero  = (remaining == '0);
  assign exhausted = rem_zero || (pix && remaining == RUN_W'(1));

`ifdef RLE_HOLD_ON_UNDERRUN_EN
  assign blank_colour = colour;
`else
  assign blank_colour = '0;
`endif

  assign state_dbg     = state;
  assign remaining_dbg = remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (frame_start) state_nx = ACTIVE;
      ACTIVE:     if (!frame_start && !drop && exhausted && head_eof) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_nx = ACTIVE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop           = 1'b0;
    remaining_nx  = remaining;
    cur_colour_nx = cur_colour;
    colour_nx     = colour;
    drop_nx       = drop;
    underrun_set  = 1'b0;
    desync_set    = 1'b0;
    case (state)
      IDLE: begin
        colour_nx = '0;
        drop_nx   = 1'b0;
      end
      WAIT_FRAME: begin
        if (pix) colour_nx = '0;
        drop_nx = 1'b0;
      end
      ACTIVE: begin
        if (frame_start) begin
          desync_set   = 1'b1;
          remaining_nx = '0;
          drop_nx      = 1'b1;
        end else if (drop) begin
          // Draining the abandoned frame: discard words through its EOF, stay ACTIVE.
          pop = head_valid;
          if (head_eof) drop_nx = 1'b0;
          if (pix) begin
            colour_nx    = '0;
            underrun_set = !head_valid;
          end
        end else begin
          if (pix && !rem_zero) begin
            colour_nx    = cur_colour;
            remaining_nx = remaining - RUN_W'(1);
          end
          if (exhausted && head_valid) begin
            pop = 1'b1;
            if (head_eof) begin
              remaining_nx = '0;
              if (pix && rem_zero) colour_nx = '0;
            end else begin
              cur_colour_nx = head_colour;
              // An idle counter hands this strobe straight to the new run's first pixel.
              if (pix && rem_zero) begin
                colour_nx    = head_colour;
                remaining_nx = head_run - RUN_W'(1);
              end else begin
                remaining_nx = head_run;
              end
            end
          end else if (pix && rem_zero) begin
            underrun_set = 1'b1;
            colour_nx    = blank_colour;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining  <= '0;
      cur_colour <= '0;
      colour     <= '0;
      drop       <= 1'b0;
      underrun   <= 1'b0;
      desync     <= 1'b0;
    end else begin
      remaining  <= remaining_nx;
      cur_colour <= cur_colour_nx;
      colour     <= colour_nx;
      drop       <= drop_nx;
      underrun   <= underrun_set || (underrun && !clear_err);
      desync     <= desync_set || (desync && !clear_err);
    end
  end

endmodule

// File: tb/tb_rle_run_expander.sv
// Directed bench for rle_run_expander: one task per scenario, hand-computed expectations.
module tb_rle_run_expander;
  import rle_vga_pkg::*;

`ifdef RLE_HOLD_ON_UNDERRUN_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start, pix_en, clear_err;
  logic [5:0] colour;
  logic       underrun, desync;
  state_t     state_dbg;
  logic [9:0] remaining_dbg;

  rle_run_expander_if #(.W(16)) bus ();

  rle_run_expander dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .frame_start   (frame_start),
    .pix_en        (pix_en),
    .clear_err     (clear_err),
    .colour        (colour),
    .underrun      (underrun),
    .desync        (desync),
    .state_dbg     (state_dbg),
    .remaining_dbg (remaining_dbg)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] word_q[$];
  bit          feed_en = 1'b1;
  bit          mon_ready = 1'b0;
  int          ready_low_run, ready_low_max;

  task automatic load_bus();
    if (feed_en && word_q.size() > 0) begin
      bus.word_valid = 1'b1;
      bus.word_in    = word_q[0];
    end else begin
      bus.word_valid = 1'b0;
      bus.word_in    = '0;
    end
  endtask

  // One clock: sample the handshake mid-cycle, then land #1 after the rising edge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = bus.word_valid && bus.word_ready;
    if (mon_ready) begin
      if (!bus.word_ready) begin
        ready_low_run++;
        if (ready_low_run > ready_low_max) ready_low_max = ready_low_run;
      end else begin
        ready_low_run = 0;
      end
    end
    @(posedge clk);
    #1;
    if (acc) void'(word_q.pop_front());
    load_bus();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; pix_en = 1'b0; clear_err = 1'b0;
    load_bus();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (colour !== 6'h00) begin errors++; $display("FAIL reset_colour: got %h want 00", colour); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (desync !== 1'b0) begin errors++; $display("FAIL reset_desync: got %b want 0", desync); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
    checks++; if (remaining_dbg !== 10'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", remaining_dbg); end
    checks++; if (bus.word_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.word_ready); end
  endtask

  task automatic test_basic_frame();
    logic [5:0] exp_c[4];
    exp_c = '{6'h2A, 6'h2A, 6'h2A, 6'h15};
    word_q = '{16'h00EA, 16'h0055, 16'h0000};
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (colour !== exp_c[i]) begin errors++; $display("FAIL basic_pix%0d: got %h want %h", i, colour, exp_c[i]); end
    end
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL basic_eof_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
    tick();
    pix_en = 1'b0;
    checks++; if (colour !== 6'h00) begin errors++; $display("FAIL basic_after_eof: got %h want 00", colour); end
    checks++; if ({underrun, desync} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {underrun, desync}); end
    checks++; if (word_q.size() !== 0) begin errors++; $display("FAIL basic_words_taken: got %0d left want 0", word_q.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) word_q.push_back(16'h0040 | 16'(i));
    word_q.push_back(16'h0000);
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    ready_low_run = 0; ready_low_max = 0; mon_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (colour !== 6'(i)) begin errors++; $display("FAIL b2b_pix%0d: got %h want %h", i, colour, 6'(i)); end
    end
    mon_ready = 1'b0;
    checks++; if (ready_low_max >= 2) begin errors++; $display("FAIL b2b_ready_gap: got %0d low cycles want <2", ready_low_max); end
    tick();
    pix_en = 1'b0;
    checks++; if (colour !== 6'h00) begin errors++; $display("FAIL b2b_after_eof: got %h want 00", colour); end
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL b2b_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_long_run();
    int cnt = 0;
    word_q = '{16'hA03F, 16'h0000};
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    repeat (640) begin
      tick();
      if (colour === 6'h3F) cnt++;
    end
    checks++; if (cnt !== 640) begin errors++; $display("FAIL long_count: got %0d want 640", cnt); end
    checks++; if (remaining_dbg !== 10'd0) begin errors++; $display("FAIL long_remaining: got %0d want 0", remaining_dbg); end
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL long_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
    tick();
    pix_en = 1'b0;
    checks++; if (colour !== 6'h00) begin errors++; $display("FAIL long_after: got %h want 00", colour); end
  endtask

  task automatic test_underrun();
    logic [5:0] exp_blank;
    exp_blank = HOLD ? 6'h11 : 6'h00;
    word_q = '{16'h0051};
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    tick();
    checks++; if (colour !== 6'h11) begin errors++; $display("FAIL under_first: got %h want 11", colour); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_early: got %b want 0", underrun); end
    tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_flag: got %b want 1", underrun); end
    checks++; if (colour !== exp_blank) begin errors++; $display("FAIL under_colour: got %h want %h", colour, exp_blank); end
    pix_en = 1'b0;
    word_q = '{16'h008B, 16'h0000};
    load_bus();
    repeat (3) tick();
    checks++; if (remaining_dbg !== 10'd2) begin errors++; $display("FAIL under_resume_load: got %0d want 2", remaining_dbg); end
    pix_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (colour !== 6'h0B) begin errors++; $display("FAIL under_resume%0d: got %h want 0b", i, colour); end
    end
    pix_en = 1'b0;
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL under_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_sticky: got %b want 1", underrun); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_clear: got %b want 0", underrun); end
    start_frame();
    pix_en = 1'b1; clear_err = 1'b1;
    tick();
    pix_en = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_clear_race: got %b want 1", underrun); end
    tick();
    clear_err = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_clear2: got %b want 0", underrun); end
    word_q = '{16'h0000};
    load_bus();
    repeat (3) tick();
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL under_eof_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
  endtask

  task automatic test_desync();
    word_q = '{16'h0142, 16'h0043, 16'h0000, 16'h00C5, 16'h0000};
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    repeat (2) tick();
    checks++; if (colour !== 6'h02) begin errors++; $display("FAIL desync_pre: got %h want 02", colour); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; pix_en = 1'b0;
    checks++; if (desync !== 1'b1) begin errors++; $display("FAIL desync_flag: got %b want 1", desync); end
    checks++; if (remaining_dbg !== 10'd0) begin errors++; $display("FAIL desync_discard: got %0d want 0", remaining_dbg); end
    checks++; if (colour !== 6'h02) begin errors++; $display("FAIL desync_pix_ignored: got %h want 02", colour); end
    repeat (5) tick();
    checks++; if (state_dbg !== ACTIVE) begin errors++; $display("FAIL desync_state: got %0d want %0d", state_dbg, ACTIVE); end
    checks++; if (remaining_dbg !== 10'd3) begin errors++; $display("FAIL desync_new_run: got %0d want 3", remaining_dbg); end
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (colour !== 6'h05) begin errors++; $display("FAIL desync_new%0d: got %h want 05", i, colour); end
    end
    pix_en = 1'b0;
    checks++; if (state_dbg !== WAIT_FRAME) begin errors++; $display("FAIL desync_end_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL desync_underrun: got %b want 0", underrun); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (desync !== 1'b0) begin errors++; $display("FAIL desync_clear: got %b want 0", desync); end
  endtask

  task automatic test_reset_mid_run();
    word_q = '{16'h1907, 16'h0000};
    load_bus();
    tick();
    start_frame();
    pix_en = 1'b1;
    repeat (50) tick();
    pix_en = 1'b0;
    checks++; if (remaining_dbg !== 10'd50) begin errors++; $display("FAIL rmid_remaining: got %0d want 50", remaining_dbg); end
    checks++; if (colour !== 6'h07) begin errors++; $display("FAIL rmid_colour: got %h want 07", colour); end
    #2 rst = 1'b1;
    #1;
    checks++; if (colour !== 6'h00) begin errors++; $display("FAIL rmid_async_colour: got %h want 00", colour); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rmid_async_state: got %0d want %0d", state_dbg, IDLE); end
    checks++; if (remaining_dbg !== 10'd0) begin errors++; $display("FAIL rmid_async_remaining: got %0d want 0", remaining_dbg); end
    checks++; if (bus.word_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_ready: got %b want 1", bus.word_ready); end
    checks++; if ({underrun, desync} !== 2'b00) begin errors++; $display("FAIL rmid_async_flags: got %b want 00", {underrun, desync}); end
    word_q.delete();
    load_bus();
    tick();
    rst = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (colour !== 6'h00 || state_dbg !== IDLE) begin
        errors++; $display("FAIL rmid_post%0d: got colour %h state %0d want 00 state %0d", i, colour, state_dbg, IDLE);
      end
    end
    pix_en = 1'b0;
  endtask

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_long_run();
    test_underrun();
    test_desync();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
